// File: rtl/cpu_run_checker_if.sv
// Run-control and register debug-read bundle for cpu_run_checker.
// master = the checker; slave = the host/core side that starts runs,
// reports retirement/halt and serves both register sets combinationally.
interface cpu_run_checker_if #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int MAX_STEPS = 100
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int MW = $clog2(NUM_REGS + 1);

    logic              start;
    logic              finish;
    logic              cpu_rst;
    logic              step_done;
    logic              halt;
    logic [AW-1:0]     reg_addr;
    logic [DATA_W-1:0] reg_rdata;
    logic [DATA_W-1:0] exp_rdata;
    logic [SW-1:0]     steps;
    logic              timeout;
    logic [MW-1:0]     mismatch_cnt;
    logic [AW-1:0]     first_bad;
    logic              pass;

    modport master (
        input  start, step_done, halt, reg_rdata, exp_rdata,
        output finish, cpu_rst, reg_addr, steps, timeout, mismatch_cnt, first_bad, pass
    );

    modport slave (
        output start, step_done, halt, reg_rdata, exp_rdata,
        input  finish, cpu_rst, reg_addr, steps, timeout, mismatch_cnt, first_bad, pass
    );
endinterface

// File: rtl/cpu_run_checker.sv
// Run controller and register checker for the multi-cycle MIPS core.
// One run: start handshake, hold the core in reset, count retired
// instructions until halt or the step limit, then walk both register sets
// through the debug read port and count masked mismatches.
module cpu_run_checker #(
    parameter int                  DATA_W       = 32,
    parameter int                  NUM_REGS     = 32,
    parameter int                  RESET_CYCLES = 2,
    parameter int                  MAX_STEPS    = 100,
    parameter logic [NUM_REGS-1:0] CHECK_MASK   = '1
) (
    input logic               clk,
    input logic               rst,
    cpu_run_checker_if.master bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int MW = $clog2(NUM_REGS + 1);
    localparam int CW = $clog2(RESET_CYCLES + 1);

    localparam logic [AW-1:0] LAST_REG  = AW'(NUM_REGS - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(MAX_STEPS - 1);
    localparam logic [SW-1:0] SAT_STEP  = SW'(MAX_STEPS);
    localparam logic [CW-1:0] RST_LOAD  = CW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc_cnt;
    logic [AW-1:0] reg_addr_q;
    logic [SW-1:0] steps_q;
    logic          timeout_q;
    logic [MW-1:0] mm_q;
    logic [AW-1:0] first_bad_q;
    logic          pass_q;
    logic          cpu_rst_c;
    logic          finish_c;
    logic          mm_hit;

    // Full-width compare of the current debug index, gated by the mask.
    assign mm_hit = CHECK_MASK[reg_addr_q] && (bus.reg_rdata != bus.exp_rdata);

    // State register; a reset anywhere aborts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and the state-decoded core reset / finish outputs.
    always_comb begin
        state_n   = state;
        cpu_rst_c = 1'b1;
        finish_c  = 1'b0;
        unique case (state)
            S_IDLE:  if (bus.start) state_n = S_RESET;
            S_RESET: if (cyc_cnt == '0) state_n = S_RUN;
            S_RUN: begin
                cpu_rst_c = 1'b0;
                // halt wins over the limit; both end the run the same way
                if (bus.halt || (bus.step_done && steps_q == LAST_STEP))
                    state_n = S_CHECK;
            end
            S_CHECK: if (reg_addr_q == LAST_REG) state_n = S_DONE;
            S_DONE: begin
                finish_c = 1'b1;
                if (!bus.start) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Run datapath: reset hold counter, step counter, register walk, results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt     <= '0;
            reg_addr_q  <= '0;
            steps_q     <= '0;
            timeout_q   <= 1'b0;
            mm_q        <= '0;
            first_bad_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        cyc_cnt     <= RST_LOAD;
                        steps_q     <= '0;
                        timeout_q   <= 1'b0;
                        mm_q        <= '0;
                        first_bad_q <= '0;
                        pass_q      <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (cyc_cnt != '0) cyc_cnt <= cyc_cnt - CW'(1);
                end
                S_RUN: begin
                    if (bus.step_done && steps_q != SAT_STEP)
                        steps_q <= steps_q + SW'(1);
                    // a step that coincides with halt never counts as a timeout
                    if (bus.step_done && !bus.halt && steps_q == LAST_STEP)
                        timeout_q <= 1'b1;
                end
                S_CHECK: begin
                    if (mm_hit) begin
                        mm_q <= mm_q + MW'(1);
                        if (mm_q == '0) first_bad_q <= reg_addr_q;
                    end
                    if (reg_addr_q == LAST_REG) begin
                        reg_addr_q <= '0;
                        pass_q     <= !timeout_q && (mm_q == '0) && !mm_hit;
                    end else begin
                        reg_addr_q <= reg_addr_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_rst      = cpu_rst_c;
    assign bus.finish       = finish_c;
    assign bus.reg_addr     = reg_addr_q;
    assign bus.steps        = steps_q;
    assign bus.timeout      = timeout_q;
    assign bus.mismatch_cnt = mm_q;
    assign bus.first_bad    = first_bad_q;
    assign bus.pass         = pass_q;
endmodule

// File: tb/tb_cpu_run_checker.sv
// Bench for cpu_run_checker: two instances (long step limit with full mask,
// short step limit with reg 3 masked out) driven by randomized runs and
// checked against a run/register model built from the block's rules.
module tb_cpu_run_checker;
    localparam int NR = 32;
    localparam int RC = 2;
    localparam int MAX_A = 100;
    localparam int MAX_B = 4;
    localparam logic [NR-1:0] MASK_A = '1;
    localparam logic [NR-1:0] MASK_B = 32'hFFFF_FFF7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] core_a [NR];
    logic [31:0] exp_a  [NR];
    logic [31:0] core_b [NR];
    logic [31:0] exp_b  [NR];

    cpu_run_checker_if #(.DATA_W(32), .NUM_REGS(NR), .MAX_STEPS(MAX_A)) ifa ();
    cpu_run_checker_if #(.DATA_W(32), .NUM_REGS(NR), .MAX_STEPS(MAX_B)) ifb ();

    cpu_run_checker #(.DATA_W(32), .NUM_REGS(NR), .RESET_CYCLES(RC), .MAX_STEPS(MAX_A),
                      .CHECK_MASK(MASK_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    cpu_run_checker #(.DATA_W(32), .NUM_REGS(NR), .RESET_CYCLES(RC), .MAX_STEPS(MAX_B),
                      .CHECK_MASK(MASK_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // core and expected register files served combinationally
    assign ifa.reg_rdata = core_a[ifa.reg_addr];
    assign ifa.exp_rdata = exp_a[ifa.reg_addr];
    assign ifb.reg_rdata = core_b[ifb.reg_addr];
    assign ifb.exp_rdata = exp_b[ifb.reg_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] finish, cpu_rst, reg_addr, steps, timeout, mm, fb, pass;
    } obs_t;

    function automatic obs_t sample(input bit b);
        obs_t o;
        if (b) begin
            o.finish = 32'(ifb.finish);   o.cpu_rst = 32'(ifb.cpu_rst);
            o.reg_addr = 32'(ifb.reg_addr); o.steps = 32'(ifb.steps);
            o.timeout = 32'(ifb.timeout); o.mm = 32'(ifb.mismatch_cnt);
            o.fb = 32'(ifb.first_bad);    o.pass = 32'(ifb.pass);
        end else begin
            o.finish = 32'(ifa.finish);   o.cpu_rst = 32'(ifa.cpu_rst);
            o.reg_addr = 32'(ifa.reg_addr); o.steps = 32'(ifa.steps);
            o.timeout = 32'(ifa.timeout); o.mm = 32'(ifa.mismatch_cnt);
            o.fb = 32'(ifa.first_bad);    o.pass = 32'(ifa.pass);
        end
        return o;
    endfunction

    // model: masked full-width inequality count and lowest differing index
    function automatic void model_regs(input bit b, output int cnt, output int first);
        logic [NR-1:0] msk;
        msk = b ? MASK_B : MASK_A;
        cnt = 0;
        first = 0;
        for (int i = 0; i < NR; i++) begin
            logic [31:0] c, e;
            c = b ? core_b[i] : core_a[i];
            e = b ? exp_b[i] : exp_a[i];
            if (msk[i] && c != e) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit b, input logic st, input logic sd, input logic hl);
        if (b) begin ifb.start = st; ifb.step_done = sd; ifb.halt = hl; end
        else   begin ifa.start = st; ifa.step_done = sd; ifa.halt = hl; end
    endtask

    // random register contents; pct = chance per register of a one-bit difference
    task automatic fill(input bit b, input int pct);
        for (int i = 0; i < NR; i++) begin
            logic [31:0] c, e;
            c = $urandom;
            e = c;
            if ($urandom_range(0, 99) < pct) e = c ^ (32'h1 << $urandom_range(0, 31));
            if (b) begin core_b[i] = c; exp_b[i] = e; end
            else   begin core_a[i] = c; exp_a[i] = e; end
        end
    endtask

    // One run with start held high. hm: 0 no halt, 1 halt after the pulses,
    // 2 halt together with the last pulse. start_lat counts edges from the one
    // that samples start to the one that drops cpu_rst. halt_lat counts edges
    // from the one that launches halt through the one that raises finish.
    task automatic run(input bit b, input int n, input int hm,
                       output int start_lat, output int halt_lat, output bit ok);
        obs_t o;
        ok = 1'b1;
        start_lat = 0;
        set_in(b, 1'b1, 1'b0, 1'b0);
        do begin tick(); start_lat++; o = sample(b); end
        while (o.cpu_rst !== 32'd0 && start_lat < 50);
        if (o.cpu_rst !== 32'd0) ok = 1'b0;
        for (int i = 1; i <= n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            set_in(b, 1'b1, 1'b1, (hm == 2 && i == n));
            tick();
            set_in(b, 1'b1, 1'b0, 1'b0);
        end
        if (hm == 1) begin
            repeat ($urandom_range(0, 2)) tick();
            set_in(b, 1'b1, 1'b0, 1'b1);
            tick();
            set_in(b, 1'b1, 1'b0, 1'b0);
        end
        halt_lat = 2;
        o = sample(b);
        for (int k = 0; k < 400 && o.finish !== 32'd1; k++) begin
            tick(); halt_lat++; o = sample(b);
        end
        if (o.finish !== 32'd1) ok = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            bit b;
            b = (d == 1);
            o = sample(b);
            checks++; if (o.finish !== 0)   begin errors++; $display("FAIL reset.finish[%0d] got %0d want 0", d, o.finish); end
            checks++; if (o.cpu_rst !== 1)  begin errors++; $display("FAIL reset.cpu_rst[%0d] got %0d want 1", d, o.cpu_rst); end
            checks++; if (o.reg_addr !== 0) begin errors++; $display("FAIL reset.reg_addr[%0d] got %0d want 0", d, o.reg_addr); end
            checks++; if (o.steps !== 0)    begin errors++; $display("FAIL reset.steps[%0d] got %0d want 0", d, o.steps); end
            checks++; if (o.timeout !== 0)  begin errors++; $display("FAIL reset.timeout[%0d] got %0d want 0", d, o.timeout); end
            checks++; if (o.mm !== 0)       begin errors++; $display("FAIL reset.mismatch_cnt[%0d] got %0d want 0", d, o.mm); end
            checks++; if (o.fb !== 0)       begin errors++; $display("FAIL reset.first_bad[%0d] got %0d want 0", d, o.fb); end
            checks++; if (o.pass !== 0)     begin errors++; $display("FAIL reset.pass[%0d] got %0d want 0", d, o.pass); end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        obs_t o;
        int k, sl, hl;
        bit ok;
        fill(1'b0, 0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0);
        k = 0;
        do begin tick(); k++; o = sample(1'b0); end while (o.cpu_rst !== 32'd0 && k < 50);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 1'b1, 1'b0); tick(); set_in(1'b0, 1'b1, 1'b0, 1'b0);
        end
        o = sample(1'b0);
        checks++; if (o.steps !== 5)   begin errors++; $display("FAIL abort.pre_steps got %0d want 5", o.steps); end
        checks++; if (o.cpu_rst !== 0) begin errors++; $display("FAIL abort.pre_cpu_rst got %0d want 0", o.cpu_rst); end
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        o = sample(1'b0);
        checks++; if (o.cpu_rst !== 1) begin errors++; $display("FAIL abort.cpu_rst got %0d want 1", o.cpu_rst); end
        checks++; if (o.steps !== 0)   begin errors++; $display("FAIL abort.steps got %0d want 0", o.steps); end
        checks++; if (o.finish !== 0)  begin errors++; $display("FAIL abort.finish got %0d want 0", o.finish); end
        rst = 1'b0;
        tick();
        run(1'b0, 3, 1, sl, hl, ok);
        o = sample(1'b0);
        checks++; if (ok !== 1'b1)  begin errors++; $display("FAIL abort.restart_done got %0d want 1", ok); end
        checks++; if (o.steps !== 3) begin errors++; $display("FAIL abort.restart_steps got %0d want 3", o.steps); end
        checks++; if (o.pass !== 1)  begin errors++; $display("FAIL abort.restart_pass got %0d want 1", o.pass); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_halt_run();
        obs_t o;
        int sl, hl;
        bit ok;
        fill(1'b0, 0);
        run(1'b0, 7, 1, sl, hl, ok);
        o = sample(1'b0);
        checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL halt_run.done got %0d want 1", ok); end
        checks++; if (sl !== RC + 1) begin errors++; $display("FAIL halt_run.start_latency got %0d want %0d", sl, RC + 1); end
        checks++; if (hl !== NR + 2) begin errors++; $display("FAIL halt_run.halt_latency got %0d want %0d", hl, NR + 2); end
        checks++; if (o.steps !== 7)   begin errors++; $display("FAIL halt_run.steps got %0d want 7", o.steps); end
        checks++; if (o.timeout !== 0) begin errors++; $display("FAIL halt_run.timeout got %0d want 0", o.timeout); end
        checks++; if (o.mm !== 0)      begin errors++; $display("FAIL halt_run.mismatch_cnt got %0d want 0", o.mm); end
        checks++; if (o.pass !== 1)    begin errors++; $display("FAIL halt_run.pass got %0d want 1", o.pass); end
        checks++; if (o.cpu_rst !== 1) begin errors++; $display("FAIL halt_run.cpu_rst got %0d want 1", o.cpu_rst); end
        checks++; if (o.reg_addr !== 0) begin errors++; $display("FAIL halt_run.reg_addr got %0d want 0", o.reg_addr); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        o = sample(1'b0);
        checks++; if (o.finish !== 0) begin errors++; $display("FAIL halt_run.finish_drop got %0d want 0", o.finish); end
        checks++; if (o.steps !== 7 || o.pass !== 1) begin errors++; $display("FAIL halt_run.hold got steps=%0d pass=%0d want 7/1", o.steps, o.pass); end
    endtask

    task automatic test_timeout();
        obs_t o;
        int sl, hl;
        bit ok;
        fill(1'b1, 0);
        run(1'b1, MAX_B + 1, 0, sl, hl, ok);
        o = sample(1'b1);
        checks++; if (ok !== 1'b1)        begin errors++; $display("FAIL timeout.done got %0d want 1", ok); end
        checks++; if (o.steps !== MAX_B)  begin errors++; $display("FAIL timeout.steps got %0d want %0d", o.steps, MAX_B); end
        checks++; if (o.timeout !== 1)    begin errors++; $display("FAIL timeout.timeout got %0d want 1", o.timeout); end
        checks++; if (o.pass !== 0)       begin errors++; $display("FAIL timeout.pass got %0d want 0", o.pass); end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_mismatch();
        obs_t o;
        int sl, hl, n;
        bit ok;
        fill(1'b0, 0);
        exp_a[3]  = exp_a[3]  ^ 32'h8000_0000;
        exp_a[17] = exp_a[17] ^ 32'h0000_0001;
        n = $urandom_range(1, 20);
        run(1'b0, n, 1, sl, hl, ok);
        o = sample(1'b0);
        checks++; if (ok !== 1'b1)     begin errors++; $display("FAIL mismatch.done got %0d want 1", ok); end
        checks++; if (o.mm !== 2)      begin errors++; $display("FAIL mismatch.mismatch_cnt got %0d want 2", o.mm); end
        checks++; if (o.fb !== 3)      begin errors++; $display("FAIL mismatch.first_bad got %0d want 3", o.fb); end
        checks++; if (o.pass !== 0)    begin errors++; $display("FAIL mismatch.pass got %0d want 0", o.pass); end
        checks++; if (o.steps !== n)   begin errors++; $display("FAIL mismatch.steps got %0d want %0d", o.steps, n); end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_mask();
        obs_t o;
        int sl, hl;
        bit ok;
        fill(1'b1, 0);
        exp_b[3] = exp_b[3] ^ 32'h0001_0000;
        run(1'b1, 2, 1, sl, hl, ok);
        o = sample(1'b1);
        checks++; if (ok !== 1'b1)  begin errors++; $display("FAIL mask.done got %0d want 1", ok); end
        checks++; if (o.mm !== 0)   begin errors++; $display("FAIL mask.mismatch_cnt got %0d want 0", o.mm); end
        checks++; if (o.pass !== 1) begin errors++; $display("FAIL mask.pass got %0d want 1", o.pass); end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_halt_step_same();
        obs_t o;
        int sl, hl;
        bit ok;
        fill(1'b1, 0);
        run(1'b1, MAX_B, 2, sl, hl, ok);
        o = sample(1'b1);
        checks++; if (ok !== 1'b1)       begin errors++; $display("FAIL halt_step.done got %0d want 1", ok); end
        checks++; if (o.steps !== MAX_B) begin errors++; $display("FAIL halt_step.steps got %0d want %0d", o.steps, MAX_B); end
        checks++; if (o.timeout !== 0)   begin errors++; $display("FAIL halt_step.timeout got %0d want 0", o.timeout); end
        checks++; if (o.pass !== 1)      begin errors++; $display("FAIL halt_step.pass got %0d want 1", o.pass); end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // randomized runs with a single low start cycle between them
    task automatic test_back_to_back();
        obs_t o;
        int sl, hl, n, hm, mx, es, ecnt, efb;
        bit ok, b, eto, ep;
        for (int it = 0; it < 10; it++) begin
            b  = 1'($urandom_range(0, 1));
            mx = b ? MAX_B : MAX_A;
            hm = $urandom_range(0, 2);
            fill(b, 10);
            if (hm == 0)      n = mx + $urandom_range(0, 1);
            else if (hm == 1) n = $urandom_range(0, b ? 6 : 20);
            else              n = $urandom_range(1, b ? 6 : 20);
            es  = (n < mx) ? n : mx;
            eto = (hm == 2) ? (n > mx) : (n >= mx);
            model_regs(b, ecnt, efb);
            ep  = (ecnt == 0) && !eto;
            run(b, n, hm, sl, hl, ok);
            o = sample(b);
            checks++; if (ok !== 1'b1)     begin errors++; $display("FAIL b2b[%0d].done got %0d want 1", it, ok); end
            checks++; if (o.steps !== es)  begin errors++; $display("FAIL b2b[%0d].steps got %0d want %0d", it, o.steps, es); end
            checks++; if (o.timeout !== 32'(eto)) begin errors++; $display("FAIL b2b[%0d].timeout got %0d want %0d", it, o.timeout, eto); end
            checks++; if (o.mm !== ecnt)   begin errors++; $display("FAIL b2b[%0d].mismatch_cnt got %0d want %0d", it, o.mm, ecnt); end
            if (ecnt != 0) begin
                checks++; if (o.fb !== efb) begin errors++; $display("FAIL b2b[%0d].first_bad got %0d want %0d", it, o.fb, efb); end
            end
            checks++; if (o.pass !== 32'(ep)) begin errors++; $display("FAIL b2b[%0d].pass got %0d want %0d", it, o.pass, ep); end
            if (hm != 0 && !eto) begin
                checks++; if (hl !== NR + 2) begin errors++; $display("FAIL b2b[%0d].halt_latency got %0d want %0d", it, hl, NR + 2); end
            end
            set_in(b, 1'b0, 1'b0, 1'b0);
            tick();
            o = sample(b);
            checks++; if (o.finish !== 0) begin errors++; $display("FAIL b2b[%0d].finish_drop got %0d want 0", it, o.finish); end
            checks++; if (o.steps !== es || o.mm !== ecnt) begin errors++; $display("FAIL b2b[%0d].hold got steps=%0d mm=%0d want %0d/%0d", it, o.steps, o.mm, es, ecnt); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        fill(1'b0, 0);
        fill(1'b1, 0);
        test_reset();
        test_abort();
        test_halt_run();
        test_timeout();
        test_mismatch();
        test_mask();
        test_halt_step_same();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
